// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
// Contents: bus encodings (htrans, hresp, hsize), the slave state enum and
// the little-endian byte-lane strobe function.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Little-endian lane strobe; illegal sizes select no lanes.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = '0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = '1;
      default:    strb = '0;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_byte_lane_gen.sv
// Combinational byte-lane strobe generator.
// Ports:
//   size    in  3  registered transfer size
//   addr_lo in  2  registered byte address bits [1:0]
//   strb    out 4  per-byte write enable, bit n = byte lane n
module ahb_byte_lane_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb
);

  assign strb = lane_strobe(size, addr_lo);

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and a two-cycle ERROR
// response for out-of-range, illegal-size and misaligned transfers.
// Ports:
//   i_hclk      in   1   clock
//   i_hreset_n  in   1   asynchronous active-low reset
//   i_hsel      in   1   slave select
//   i_haddr     in   32  address-phase byte address
//   i_htrans    in   2   transfer type
//   i_hwrite    in   1   1 = write
//   i_hsize     in   3   transfer size
//   i_hburst    in   3   burst type (ignored)
//   i_hwdata    in   32  write data (data phase)
//   i_hready    in   1   bus-wide HREADY
//   o_hready    out  1   data phase complete
//   o_hresp     out  2   OKAY / ERROR
//   o_hrdata    out  32  read data
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_hclk,
  input  logic        i_hreset_n,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [31:0] i_hwdata,
  input  logic        i_hready,
  output logic        o_hready,
  output logic [1:0]  o_hresp,
  output logic [31:0] o_hrdata
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  // Counter holds remaining waits minus one so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e  state, state_next;
  logic [3:0]    wait_cnt;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;

  logic          accept;
  logic          addr_err;
  logic [3:0]    lane_strb;
  logic [AW-1:0] idx;
  logic          wr_en;
  logic          rd_en;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          unused_hburst;
  assign unused_hburst = ^i_hburst;

  // New address phases are only taken while no data phase is stalling the bus;
  // a pipelined phase seen during ERR2 is deliberately dropped.
  assign accept = ((state == ST_IDLE) || (state == ST_DATA)) && i_hsel && i_hready &&
                  ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

  assign addr_err = ({1'b0, i_haddr} >= ADDR_LIMIT) ||
                    (i_hsize > HSIZE_WORD) ||
                    ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                    ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));

  assign idx   = addr_q[AW+1:2];
  assign wr_en = (state == ST_DATA) && write_q;

  ahb_byte_lane_gen u_lane (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .strb    (lane_strb)
  );

  // State register
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          if (addr_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_next = ST_DATA;
      end
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    rd_en    = 1'b0;
    case (state)
      ST_WAIT: o_hready = 1'b0;
      ST_DATA: rd_en    = !write_q;
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
      end
      ST_ERR2: o_hresp = HRESP_ERROR;
      default: ;
    endcase
    o_hrdata = rd_en ? mem[idx] : '0;
  end

  // Address-phase capture and wait counter
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q   <= i_haddr[AW+1:0];
        write_q  <= i_hwrite;
        size_q   <= i_hsize;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Storage is not reset; reset forces IDLE, which gates any pending write.
  always_ff @(posedge i_hclk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_strb[i]) mem[idx][8*i +: 8] <= i_hwdata[8*i +: 8];
      end
    end
  end

endmodule
